// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl: valid/ready initiator for one sram22 single-port macro.
// Ports:
//   clk, rst_n (async, active low)
//   req_*      request stream (we/wmask/addr/wdata) in, req_ready out
//   rsp_*      read-response stream out, rsp_ready in
//   sram_*     macro pins; we/wmask/addr/din out, dout in (1-cycle read)
module sram22_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = 1,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_pend_q, rd_pend_d;

    logic                  fire;
    logic                  push;
    logic                  pop;
    logic                  read_credit;
    logic [CNT_W:0]        occ;

    assign push = rd_pend_q;
    assign rsp_valid = (count_q != '0);
    assign pop = rsp_valid && rsp_ready;

    // Slots already claimed by buffered or in-flight reads, less the one
    // leaving this cycle. pop implies count_q >= 1, so no underflow.
    assign occ = {1'b0, count_q}
               + (CNT_W + 1)'(rd_pend_q)
               - (CNT_W + 1)'(pop);
    assign read_credit = (occ < DEPTH_W);

    // rst_n gates ready so nothing fires while reset is held.
    assign req_ready = rst_n && (req_we || read_credit);
    assign fire = req_valid && req_ready;

    assign sram_we    = fire && req_we;
    assign sram_wmask = req_wmask;
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;

    assign rsp_rdata = fifo_q[rd_ptr_q];

    always_comb begin
        rd_pend_d = fire && !req_we;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Storage needs no reset; validity lives in count_q. sram_dout is
    // sampled here before any write issued this cycle reaches the macro.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_dout;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_W'(RSP_DEPTH)))
    );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// tb_sram22_port_ctrl: scoreboard bench with a behavioural sram model,
// directed scenarios and a randomized phase.
module tb_sram22_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int MW = 1;
    localparam int SLICE = DW / MW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    sram22_port_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WMASK_WIDTH(MW), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_wmask(req_wmask),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural macro: masked write, dout one cycle after the edge.
    logic [DW-1:0] sram_mem [1 << AW];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < DW; b++) begin
                if (sram_wmask[b / SLICE]) sram_mem[sram_addr][b] <= sram_din[b];
            end
        end
        sram_dout <= sram_mem[sram_addr];
    end

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] exp_q [$];
    int            pop_cyc [$];
    int            checks = 0;
    int            errors = 0;
    int            rsp_seen = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW; b++) if (m[b / SLICE]) r[b] = nw[b];
        return r;
    endfunction

    // Monitor
    bit            held = 0;
    logic [DW-1:0] held_val;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rsp_ready) begin
                rsp_seen++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h expected none (cycle %0d)",
                             rsp_rdata, cyc);
                end else begin
                    chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, exp_q.pop_front()});
                end
                held = 0;
            end else begin
                if (held) chk("rsp_hold", {32'h0, rsp_rdata}, {32'h0, held_val});
                held = 1;
                held_val = rsp_rdata;
            end
        end else begin
            held = 0;
        end
    end

    // Driver: called at posedge+1, returns at next posedge+1.
    logic          s_we, s_rv, s_rdy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    int            fire_cyc;

    task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m,
                         input bit rr, output bit fired);
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_wmask = m;
        rsp_ready = rr;
        @(negedge clk);
        s_we = sram_we;
        s_addr = sram_addr;
        s_din = sram_din;
        s_rv = rsp_valid;
        s_rdy = req_ready;
        fired = req_valid && req_ready;
        fire_cyc = cyc;
        if (fired) begin
            if (we) ref_mem[a] = merge(ref_mem[a], d, m);
            else exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        bit f;
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, rr, f);
    endtask

    initial begin
        bit f;
        int f0, acc;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_wmask = '1;
        req_addr = '0;
        req_wdata = 32'h1234_5678;
        rsp_ready = 1'b1;
        #2;
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
        chk("rst_sram_we", {63'h0, sram_we}, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        #1;
        chk("idle_read_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk);
        #1;

        // Write then read-after-write, latency 2
        drive(1, 1, 9'h005, 32'hDEAD_BEEF, 1'b1, 1, f);
        chk("wr_fire", {63'h0, f}, 64'h1);
        chk("wr_sram_we", {63'h0, s_we}, 64'h1);
        chk("wr_sram_addr", {55'h0, s_addr}, 64'h5);
        chk("wr_sram_din", {32'h0, s_din}, 64'hDEAD_BEEF);
        pop_cyc.delete();
        drive(1, 0, 9'h005, '0, '0, 1, f);
        chk("rd_fire", {63'h0, f}, 64'h1);
        chk("rd_sram_we", {63'h0, s_we}, 64'h0);
        f0 = fire_cyc;
        drive(0, 0, '0, '0, '0, 1, f);
        chk("rd_lat_c1", {63'h0, s_rv}, 64'h0);
        drive(0, 0, '0, '0, '0, 1, f);
        chk("rd_lat_c2", {63'h0, s_rv}, 64'h1);
        chk("rd_lat_n", 64'(pop_cyc.size()), 64'h1);
        if (pop_cyc.size() > 0) chk("rd_lat_cyc", 64'(pop_cyc[0]), 64'(f0 + 2));
        idle(2, 1);

        // Back-to-back reads @0..7
        for (int i = 0; i < 8; i++)
            drive(1, 1, AW'(i), DW'(i * 32'h11), '1, 1, f);
        pop_cyc.delete();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, AW'(i), '0, '0, 1, f);
            if (i == 0) f0 = fire_cyc;
            acc += int'(f);
        end
        idle(4, 1);
        chk("b2b_accepted", 64'(acc), 64'h8);
        chk("b2b_rsp_n", 64'(pop_cyc.size()), 64'h8);
        for (int i = 0; i < 8 && i < pop_cyc.size(); i++)
            chk("b2b_rsp_cyc", 64'(pop_cyc[i]), 64'(f0 + 2 + i));

        // Backpressure: only RSP_DEPTH reads accepted, writes still go
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, AW'(i), '0, '0, 0, f);
            acc += int'(f);
        end
        chk("bp_accepted", 64'(acc), 64'h2);
        chk("bp_read_ready", {63'h0, s_rdy}, 64'h0);
        drive(1, 1, 9'h033, 32'hCAFE_0033, '1, 0, f);
        chk("bp_write_fire", {63'h0, f}, 64'h1);
        idle(4, 1);
        chk("bp_drained", 64'(exp_q.size()), 64'h0);

        // Read then write next cycle
        drive(1, 1, 9'h010, 32'hAAAA_0010, '1, 1, f);
        drive(1, 1, 9'h020, 32'hBBBB_0020, '1, 1, f);
        drive(1, 0, 9'h010, '0, '0, 1, f);
        drive(1, 1, 9'h020, 32'h5555_0020, '1, 1, f);
        drive(1, 1, 9'h010, 32'h7777_0010, '0, 1, f);
        drive(1, 0, 9'h020, '0, '0, 1, f);
        drive(1, 0, 9'h010, '0, '0, 1, f);
        idle(4, 1);
        chk("raw_drained", 64'(exp_q.size()), 64'h0);

        // Reset with one buffered and one in-flight read
        drive(1, 0, 9'h001, '0, '0, 0, f);
        drive(1, 0, 9'h002, '0, '0, 0, f);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("mid_rst_req_ready", {63'h0, req_ready}, 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc = rsp_seen;
        idle(6, 1);
        chk("no_stale_rsp", 64'(rsp_seen - acc), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit v, we, rr;
            v = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 3) != 0);
            drive(v, we, AW'($urandom_range(0, 15)), DW'($urandom),
                  MW'($urandom_range(0, 1)), rr, f);
            if (we) chk("rand_wr_ready", {63'h0, s_rdy}, 64'h1);
        end
        idle(6, 1);
        chk("final_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
